// File: rtl/buscaminas_pkg.sv
// Shared types and constants for the minesweeper board sequencer.
// Cell word layout, board geometry, LFSR taps and the neighbour-count helper.
package buscaminas_pkg;

    localparam int unsigned FILAS        = 8;
    localparam int unsigned COLS         = 8;
    localparam int unsigned CELDAS       = FILAS * COLS;
    localparam int unsigned DIR_W        = 6;
    localparam int unsigned CELDA_W      = 9;
    localparam int unsigned BIT_BOMBA    = 8;
    localparam int unsigned BIT_REVELADA = 7;
    localparam int unsigned BIT_BANDERA  = 6;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        CLEAR      = 3'd1,
        PLACE      = 3'd2,
        COUNT      = 3'd3,
        PLAY       = 3'd4,
        LOST       = 3'd5,
        WON        = 3'd6,
        REVEAL_ALL = 3'd7
    } estado_t;

    // Bombs among the in-bounds 8-neighbours of a cell; edges do not wrap.
    function automatic logic [3:0] contar_vecinos(input logic [CELDAS-1:0] bombas,
                                                  input logic [DIR_W-1:0]  dir);
        logic [3:0] total;
        int f;
        int c;
        total = '0;
        for (int df = -1; df <= 1; df++) begin
            for (int dc = -1; dc <= 1; dc++) begin
                f = int'(dir[5:3]) + df;
                c = int'(dir[2:0]) + dc;
                if ((df != 0 || dc != 0) && f >= 0 && f < int'(FILAS) &&
                    c >= 0 && c < int'(COLS))
                    total = total + 4'(bombas[DIR_W'(f * int'(COLS) + c)]);
            end
        end
        return total;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR used to draw candidate bomb positions.
module lfsr16
    import buscaminas_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        enable,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (!rst)
            state <= '0;
        else if (load)
            state <= seed;
        else if (enable)
            state <= state[0] ? ((state >> 1) ^ LFSR_TAPS) : (state >> 1);
    end

endmodule

// File: rtl/secuenciador_tablero.sv
// Minesweeper game sequencer: clear, bomb placement, neighbour counts, then play.
// Optional BUSCAMINAS_REVELAR_FIN_EN: on a bomb hit, sweep the board revealing all bombs.
module secuenciador_tablero
    import buscaminas_pkg::*;
#(
    parameter int unsigned CANT_MAX    = 40,
    parameter logic [15:0] SEMILLA_DEF = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [DIR_W-1:0]   cantidad_bombas,
    input  logic [15:0]        semilla,
    input  logic               accion_valid,
    output logic               accion_ready,
    input  logic               accion_tipo,
    input  logic [2:0]         accion_fila,
    input  logic [2:0]         accion_col,
    input  logic [DIR_W-1:0]   rd_addr,
    output logic [CELDA_W-1:0] rd_data,
    output logic               listo,
    output logic               perdio,
    output logic               gano,
    output logic [DIR_W-1:0]   bombas_colocadas,
    output logic [2:0]         estado
);

    estado_t estado_q, estado_d;

    logic [CELDA_W-1:0] celdas [CELDAS];
    logic [CELDAS-1:0]  bombas;
    logic [DIR_W-1:0]   ptr;
    logic [DIR_W-1:0]   n_obj;
    logic [DIR_W-1:0]   n_sol;
    logic [6:0]         reveladas;
    logic [6:0]         meta;
    logic [15:0]        semilla_ef;
    logic [15:0]        lfsr_estado;
    logic               lfsr_unused;
    logic [DIR_W-1:0]   candidata;
    logic [DIR_W-1:0]   dir_accion;
    logic [CELDA_W-1:0] celda_cand;
    logic [CELDA_W-1:0] celda_ptr;
    logic [CELDA_W-1:0] celda_accion;
    logic               acepta;

    logic               we_c;
    logic [DIR_W-1:0]   waddr_c;
    logic [CELDA_W-1:0] wdata_c;
    logic               ptr_inc_c;
    logic               coloca_c;
    logic               revela_c;
    logic               lfsr_en_c;

    assign semilla_ef   = (semilla == '0) ? SEMILLA_DEF : semilla;
    assign candidata    = lfsr_estado[DIR_W-1:0];
    assign lfsr_unused  = ^lfsr_estado[15:DIR_W];
    assign dir_accion   = {accion_fila, accion_col};
    assign celda_cand   = celdas[candidata];
    assign celda_ptr    = celdas[ptr];
    assign celda_accion = celdas[dir_accion];
    assign acepta       = accion_valid && accion_ready && !start;
    assign meta         = 7'(CELDAS) - {1'b0, n_obj};
    assign estado       = estado_q;

    lfsr16 u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load   (start),
        .seed   (semilla_ef),
        .enable (lfsr_en_c),
        .state  (lfsr_estado)
    );

    // Requested bomb count clamped to 1..CANT_MAX.
    always_comb begin
        n_sol = cantidad_bombas;
        if (cantidad_bombas == '0)
            n_sol = DIR_W'(1);
        else if (cantidad_bombas > DIR_W'(CANT_MAX))
            n_sol = DIR_W'(CANT_MAX);
    end

    always_comb begin
        bombas = '0;
        for (int i = 0; i < int'(CELDAS); i++)
            bombas[i] = celdas[i][BIT_BOMBA];
    end

    // State register plus status flags derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado_q     <= IDLE;
            accion_ready <= 1'b0;
            listo        <= 1'b0;
            perdio       <= 1'b0;
            gano         <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            accion_ready <= (estado_d == PLAY);
            listo        <= (estado_d inside {PLAY, LOST, WON});
            perdio       <= (estado_d == LOST);
            gano         <= (estado_d == WON);
        end
    end

    always_comb begin
        estado_d = estado_q;
        if (start) begin
            estado_d = CLEAR;
        end else begin
            case (estado_q)
                IDLE:  estado_d = IDLE;
                CLEAR: if (ptr == '1) estado_d = PLACE;
                PLACE: if (!celda_cand[BIT_BOMBA] &&
                           (bombas_colocadas + DIR_W'(1)) == n_obj) estado_d = COUNT;
                COUNT: if (ptr == '1) estado_d = PLAY;
                PLAY: begin
                    if (acepta && !accion_tipo && !celda_accion[BIT_REVELADA] &&
                        !celda_accion[BIT_BANDERA]) begin
                        if (celda_accion[BIT_BOMBA]) begin
`ifdef BUSCAMINAS_REVELAR_FIN_EN
                            estado_d = REVEAL_ALL;
`else
                            estado_d = LOST;
`endif
                        end else if ((reveladas + 7'd1) == meta) begin
                            estado_d = WON;
                        end
                    end
                end
`ifdef BUSCAMINAS_REVELAR_FIN_EN
                REVEAL_ALL: if (ptr == '1) estado_d = LOST;
`endif
                LOST:    estado_d = LOST;
                WON:     estado_d = WON;
                default: estado_d = IDLE;
            endcase
        end
    end

    // Per-state board write and counter controls; a start pulse suppresses all of them.
    always_comb begin
        we_c      = 1'b0;
        waddr_c   = ptr;
        wdata_c   = '0;
        ptr_inc_c = 1'b0;
        coloca_c  = 1'b0;
        revela_c  = 1'b0;
        lfsr_en_c = 1'b0;
        if (!start) begin
            case (estado_q)
                CLEAR: begin
                    we_c      = 1'b1;
                    ptr_inc_c = 1'b1;
                end
                PLACE: begin
                    lfsr_en_c          = 1'b1;
                    waddr_c            = candidata;
                    wdata_c            = celda_cand;
                    wdata_c[BIT_BOMBA] = 1'b1;
                    coloca_c           = !celda_cand[BIT_BOMBA];
                    we_c               = coloca_c;
                end
                COUNT: begin
                    we_c      = 1'b1;
                    ptr_inc_c = 1'b1;
                    wdata_c   = {celda_ptr[CELDA_W-1:4], contar_vecinos(bombas, ptr)};
                end
                PLAY: begin
                    if (acepta) begin
                        waddr_c = dir_accion;
                        wdata_c = celda_accion;
                        if (accion_tipo) begin
                            we_c                 = !celda_accion[BIT_REVELADA];
                            wdata_c[BIT_BANDERA] = !celda_accion[BIT_BANDERA];
                        end else if (!celda_accion[BIT_REVELADA] && !celda_accion[BIT_BANDERA]) begin
                            we_c                  = 1'b1;
                            wdata_c[BIT_REVELADA] = 1'b1;
                            revela_c              = !celda_accion[BIT_BOMBA];
                        end
                    end
                end
`ifdef BUSCAMINAS_REVELAR_FIN_EN
                REVEAL_ALL: begin
                    ptr_inc_c             = 1'b1;
                    we_c                  = celda_ptr[BIT_BOMBA];
                    wdata_c               = celda_ptr;
                    wdata_c[BIT_REVELADA] = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // Board storage, sweep pointer, counters and the registered renderer port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(CELDAS); i++)
                celdas[i] <= '0;
            ptr              <= '0;
            n_obj            <= '0;
            reveladas        <= '0;
            bombas_colocadas <= '0;
            rd_data          <= '0;
        end else begin
            rd_data <= celdas[rd_addr];
            if (we_c)
                celdas[waddr_c] <= wdata_c;
            if (start) begin
                ptr              <= '0;
                n_obj            <= n_sol;
                reveladas        <= '0;
                bombas_colocadas <= '0;
            end else begin
                if (ptr_inc_c)
                    ptr <= ptr + DIR_W'(1);
                if (coloca_c)
                    bombas_colocadas <= bombas_colocadas + DIR_W'(1);
                if (revela_c)
                    reveladas <= reveladas + 7'd1;
            end
        end
    end

endmodule

// File: tb/tb_secuenciador_tablero.sv
// Self-checking bench for secuenciador_tablero against a game-level model of the board.
module tb_secuenciador_tablero;

    localparam int unsigned CANT_MAX    = 40;
    localparam logic [15:0] SEMILLA_DEF = 16'hACE1;
    localparam int ST_IDLE  = 0;
    localparam int ST_CLEAR = 1;
    localparam int ST_PLACE = 2;
    localparam int ST_COUNT = 3;
    localparam int ST_PLAY  = 4;
    localparam int ST_LOST  = 5;
    localparam int ST_WON   = 6;
`ifdef BUSCAMINAS_REVELAR_FIN_EN
    localparam int ST_REVEAL = 7;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  cantidad_bombas;
    logic [15:0] semilla;
    logic        accion_valid;
    logic        accion_ready;
    logic        accion_tipo;
    logic [2:0]  accion_fila;
    logic [2:0]  accion_col;
    logic [5:0]  rd_addr;
    logic [8:0]  rd_data;
    logic        listo;
    logic        perdio;
    logic        gano;
    logic [5:0]  bombas_colocadas;
    logic [2:0]  estado;

    always #5 clk = ~clk;

    secuenciador_tablero #(.CANT_MAX(CANT_MAX), .SEMILLA_DEF(SEMILLA_DEF)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .cantidad_bombas  (cantidad_bombas),
        .semilla          (semilla),
        .accion_valid     (accion_valid),
        .accion_ready     (accion_ready),
        .accion_tipo      (accion_tipo),
        .accion_fila      (accion_fila),
        .accion_col       (accion_col),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .listo            (listo),
        .perdio           (perdio),
        .gano             (gano),
        .bombas_colocadas (bombas_colocadas),
        .estado           (estado)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int exp_estado, exp_listo, exp_perdio, exp_gano, exp_ready, exp_bombas;

    bit m_bomb [64];
    bit m_rev  [64];
    bit m_flag [64];
    int m_cnt  [64];
    int m_n, m_nrev, m_state, m_draws;
    int placed_by [$];

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("estado", 32'(estado), exp_estado);
            check("listo", 32'(listo), exp_listo);
            check("perdio", 32'(perdio), exp_perdio);
            check("gano", 32'(gano), exp_gano);
            check("accion_ready", 32'(accion_ready), exp_ready);
            check("bombas_colocadas", 32'(bombas_colocadas), exp_bombas);
        end
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic int clamp_n(input int c);
        if (c == 0) return 1;
        if (c > int'(CANT_MAX)) return int'(CANT_MAX);
        return c;
    endfunction

    function automatic int word(input int a);
        return (m_bomb[a] ? 256 : 0) + (m_rev[a] ? 128 : 0) + (m_flag[a] ? 64 : 0) + m_cnt[a];
    endfunction

    task automatic set_exp(input int st, input int li, input int pe, input int ga, input int re, input int bo);
        exp_estado = st; exp_listo = li; exp_perdio = pe;
        exp_gano = ga; exp_ready = re; exp_bombas = bo;
    endtask

    task automatic model_clear();
        for (int a = 0; a < 64; a++) begin
            m_bomb[a] = 1'b0; m_rev[a] = 1'b0; m_flag[a] = 1'b0; m_cnt[a] = 0;
        end
        m_nrev = 0;
    endtask

    // Replays the placement draws and derives neighbour counts bomb by bomb.
    task automatic model_new_game(input int cant, input logic [15:0] sem);
        logic [15:0] s;
        int placed, a, fb, cb;
        model_clear();
        m_n = clamp_n(cant);
        s = (sem == 16'h0) ? SEMILLA_DEF : sem;
        placed_by.delete();
        placed_by.push_back(0);
        placed = 0;
        m_draws = 0;
        while (placed < m_n && m_draws < 100000) begin
            a = int'(s[5:0]);
            if (!m_bomb[a]) begin
                m_bomb[a] = 1'b1;
                placed++;
            end
            m_draws++;
            placed_by.push_back(placed);
            s = lfsr_next(s);
        end
        for (int b = 0; b < 64; b++) begin
            if (m_bomb[b]) begin
                fb = b / 8;
                cb = b % 8;
                for (int r = fb - 1; r <= fb + 1; r++)
                    for (int c = cb - 1; c <= cb + 1; c++)
                        if (r >= 0 && r < 8 && c >= 0 && c < 8 && !(r == fb && c == cb))
                            m_cnt[r * 8 + c]++;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int cant, input logic [15:0] sem, input int stop_at);
        model_new_game(cant, sem);
        m_state = ST_CLEAR;
        cantidad_bombas = 6'(cant);
        semilla = sem;
        start = 1'b1;
        for (int c = 0; c <= 128 + m_draws; c++) begin
            tick();
            if (c == 0) begin
                start = 1'b0;
                accion_valid = 1'b0;
            end
            if (c < 64) set_exp(ST_CLEAR, 0, 0, 0, 0, 0);
            else if (c < 64 + m_draws) set_exp(ST_PLACE, 0, 0, 0, 0, placed_by[c - 64]);
            else if (c < 128 + m_draws) set_exp(ST_COUNT, 0, 0, 0, 0, m_n);
            else set_exp(ST_PLAY, 1, 0, 0, 1, m_n);
            if (c == stop_at) return;
        end
        m_state = ST_PLAY;
    endtask

    task automatic model_apply(input bit tipo, input int a);
        if (m_state != ST_PLAY) return;
        if (tipo) begin
            if (!m_rev[a]) m_flag[a] = !m_flag[a];
        end else if (!m_rev[a] && !m_flag[a]) begin
            m_rev[a] = 1'b1;
            if (m_bomb[a]) begin
`ifdef BUSCAMINAS_REVELAR_FIN_EN
                m_state = ST_REVEAL;
                set_exp(ST_REVEAL, 0, 0, 0, 0, m_n);
`else
                m_state = ST_LOST;
                set_exp(ST_LOST, 1, 1, 0, 0, m_n);
`endif
            end else begin
                m_nrev++;
                if (m_nrev == 64 - m_n) begin
                    m_state = ST_WON;
                    set_exp(ST_WON, 1, 0, 1, 0, m_n);
                end
            end
        end
    endtask

    task automatic act(input bit tipo, input int a);
        accion_valid = 1'b1;
        accion_tipo  = tipo;
        accion_fila  = 3'(a / 8);
        accion_col   = 3'(a % 8);
        tick();
        model_apply(tipo, a);
    endtask

`ifdef BUSCAMINAS_REVELAR_FIN_EN
    task automatic finish_reveal();
        accion_valid = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 64) begin
                for (int a = 0; a < 64; a++)
                    if (m_bomb[a]) m_rev[a] = 1'b1;
                m_state = ST_LOST;
                set_exp(ST_LOST, 1, 1, 0, 0, m_n);
            end
        end
    endtask
`endif

    task automatic read_cell(input int a, output logic [8:0] d);
        rd_addr = 6'(a);
        tick();
        d = rd_data;
    endtask

    task automatic check_board();
        logic [8:0] d;
        int nb;
        nb = 0;
        for (int a = 0; a < 64; a++) begin
            read_cell(a, d);
            check($sformatf("celda[%0d]", a), 32'(d), word(a));
            if (d[8]) nb++;
        end
        check("num_bombas_tablero", nb, m_n);
    endtask

    initial begin
        logic [8:0] d;
        int safe [$];
        int bomba;

        rst = 1'b0; start = 1'b0; cantidad_bombas = '0; semilla = '0;
        accion_valid = 1'b0; accion_tipo = 1'b0; accion_fila = '0; accion_col = '0; rd_addr = '0;
        m_n = 0; m_state = ST_IDLE;
        model_clear();

        // Reset held for two edges
        tick();
        tick();
        set_exp(ST_IDLE, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        check("rd_data_reset", 32'(rd_data), 0);
        rst = 1'b1;
        check_board();

        // Model pins: hand-computed LFSR steps and clamps
        check("pin_lfsr_odd", 32'(lfsr_next(16'h0001)), 32'h0000B400);
        check("pin_lfsr_even", 32'(lfsr_next(16'h0002)), 32'h00000001);
        check("pin_clamp_0", clamp_n(0), 1);
        check("pin_clamp_63", clamp_n(63), 40);

        // Ten bombs, seed 1234: first draw lands on address 52
        do_start(10, 16'h1234, -1);
        check("listo_play", 32'(listo), 1);
        check_board();
        read_cell(52, d);
        check("pin_c52_bomba", 32'(d[8]), 1);

        // Win: flag a safe cell, reveal the rest back-to-back with ignored actions mixed in
        safe.delete();
        bomba = 0;
        for (int a = 0; a < 64; a++) begin
            if (!m_bomb[a]) safe.push_back(a);
            else bomba = a;
        end
        check("safe_cells", safe.size(), 54);
        act(1'b1, safe[0]);
        act(1'b0, safe[0]);
        for (int i = 1; i < safe.size(); i++) begin
            act(1'b0, safe[i]);
            if (i == 5) act(1'b0, safe[3]);
        end
        act(1'b1, safe[1]);
        check("gano_before_last", 32'(gano), 0);
        act(1'b1, safe[0]);
        act(1'b0, safe[0]);
        check("gano_after_54", 32'(gano), 1);
        act(1'b0, bomba);
        accion_valid = 1'b0;
        tick();
        check("ready_won", 32'(accion_ready), 0);
        check_board();

        // Restart from WON with zero bombs requested: one bomb at 33 from the default seed
        do_start(0, 16'h0000, -1);
        check("pin_draws_n1", m_draws, 1);
        check("gano_cleared", 32'(gano), 0);
        check_board();
        read_cell(33, d);
        check("pin_c33", 32'(d), 32'h100);
        read_cell(24, d);
        check("pin_c24", 32'(d), 32'h001);
        read_cell(0, d);
        check("pin_c0", 32'(d), 32'h000);

        // Loss on the single bomb
        act(1'b0, 33);
`ifdef BUSCAMINAS_REVELAR_FIN_EN
        finish_reveal();
`endif
        check("perdio_set", 32'(perdio), 1);
        check("ready_lost", 32'(accion_ready), 0);
        accion_valid = 1'b0;
        tick();
        read_cell(33, d);
        check("pin_c33_revealed", 32'(d), 32'h180);
        check_board();

        // Clamp to CANT_MAX
        do_start(63, 16'hBEEF, -1);
        check("clamp_40", 32'(bombas_colocadas), 40);
        check_board();

        // Start coincident with a bomb reveal drops the action; then reset mid-PLACE
        bomba = 0;
        for (int a = 0; a < 64; a++)
            if (m_bomb[a]) bomba = a;
        accion_valid = 1'b1;
        accion_tipo  = 1'b0;
        accion_fila  = 3'(bomba / 8);
        accion_col   = 3'(bomba % 8);
        do_start(10, 16'h5555, 66);
        check("mid_place", 32'(estado), ST_PLACE);
        rst = 1'b0;
        tick();
        model_clear();
        m_n = 0;
        m_state = ST_IDLE;
        set_exp(ST_IDLE, 0, 0, 0, 0, 0);
        rst = 1'b1;
        check("rd_data_midreset", 32'(rd_data), 0);
        check_board();

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run exceeded time limit at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
